rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Parametrised N-channel, W-bit multiplexer that arbitrates among the channels instead of taking an external select.
- Each input channel has a valid/ready handshake. The winner is chosen by round-robin or fixed-priority mode, and its word is captured into a registered output stage with a valid/ready handshake.
- Sits between multiple producer blocks and a single shared consumer (bus, ALU port, FIFO). It replaces hard-wired 4:1 select muxes wherever sources contend.

Parameters:
- W, 8, data width of every channel and of the output.
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), derived localparam; width of the channel index. Not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- mode  input  1  0 = round-robin, 1 = fixed priority (index 0 highest).
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*W  flattened channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel accept; at most one bit is high in any cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async, immediate, no clock needed): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is combinational and is 0 while out_valid=0 and no in_valid is set.
- A reset mid-operation discards any held word. No partial transfer survives.
- Load enable: load_en = !out_valid | out_ready. With one output register, throughput is one word per cycle under continuous out_ready.
- Grant is combinational from in_valid, mode and ptr:
  - Round-robin: first valid channel scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N, wrap-around).
  - Fixed priority: lowest-index valid channel; ptr is ignored.
- in_ready[g] = load_en & grant[g], and all other in_ready bits are 0. A transfer on channel g occurs when in_valid[g] & in_ready[g].
- On a transfer edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
- Round-robin mode only: ptr <= (g == N-1) ? 0 : g+1. In fixed mode ptr holds its value.
- When load_en=1 and no in_valid is set: out_valid <= 0 if it was 1 (consumed). out_data and out_sel hold their last values.
- Simultaneous consume and load (out_valid=1, out_ready=1, any in_valid): the new word replaces the old in the same edge, with no bubble.
- Backpressure (out_valid=1, out_ready=0): all in_ready=0; out_data, out_sel and ptr are frozen.
- Input-side rules:
  - A producer may drop in_valid before it is granted; no word is captured in that case.
  - The arbiter never grants a channel whose in_valid is 0.
- A mode change takes effect on the next grant decision. It never alters a held word or ptr.
- Latency: 1 cycle from an accepted input to out_valid.

Decomposition:
- Shared package mux_pkg:
  - MODE_RR=1'b0 and MODE_FIXED=1'b1 constants.
  - A function computing the rotated first-one index, reusable by other arbiters.
- One sub-module, rr_arbiter: N-bit request in, ptr in, mode in; one-hot grant and encoded index out. Purely combinational.
- Top level rr_mux_arb holds the ptr register, the output register and the data selection.

Test Plan (N=4, W=8):
- Reset: assert rst=1 mid-clock with out_valid=1 -> out_valid, out_data and out_sel go to 0 immediately, before the next edge; in_ready=4'b0000 once in_valid=0.
- Round-robin fairness: mode=0, all in_valid=1, in_data = A3,A2,A1,A0 (channel 3..0), out_ready=1 -> out_data A0,A1,A2,A3,A0 on consecutive cycles; out_sel 0,1,2,3,0.
- Backpressure: load A0, then hold out_ready=0 for 3 cycles -> out_data=A0 stable and in_ready=0000 throughout. Raise out_ready -> A1 appears on the next edge with no lost or duplicated word.
- Fixed priority: mode=1, in_valid=4'b1010 continuously -> out_sel=1 every cycle; channel 3 is never granted.
- Wrap-around: ptr=3 after a channel-2 transfer (rr), then only in_valid[0]=1 -> channel 0 granted and ptr becomes 1. Next, in_valid=4'b1001 -> channel 3 granted (scan starts at 1).
- Drain: one word of 8'h5A from channel 2, then in_valid=0 and out_ready=1 -> out_valid is 1 for exactly one cycle, then 0; out_data stays 8'h5A.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for arbitrated multiplexers: mode encodings and a
// rotating first-one search usable by any round-robin arbiter.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Widest request vector the search function handles.
  localparam int MAX_N = 32;

  // Returns the index of the first set bit of req[n-1:0], scanning
  // start, start+1, ..., n-1, 0, ..., start-1. Returns -1 when no bit is set.
  // The loop runs downward so the last hit written is the earliest in scan order.
  function automatic int rot_first_one(input logic [MAX_N-1:0] req,
                                       input int n,
                                       input int start);
    int result;
    int idx;
    result = -1;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) result = idx;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed priority with
// channel 0 highest. Produces a one-hot grant and its encoded index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [SELW-1:0] start;
  int              hit;

  // Pick the scan origin and search for the first requesting channel.
  always_comb begin
    start = (mode == MODE_FIXED) ? '0 : ptr;
    hit   = rot_first_one(MAX_N'(req), N, int'(start));
    any   = |req;
    idx   = any ? SELW'(hit) : '0;
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel arbitrated multiplexer with a single registered output stage.
// Holds the round-robin pointer, the output register and the data select.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [N-1:0]      in_valid,
  input  logic [N*W-1:0]    in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic [W-1:0]    chan_data [N];
  logic [N-1:0]    grant;
  logic [SELW-1:0] grant_idx;
  logic            grant_any;
  logic            load_en;

  logic            valid_reg, valid_next;
  logic [W-1:0]    data_reg, data_next;
  logic [SELW-1:0] sel_reg, sel_next;
  logic [SELW-1:0] ptr_reg, ptr_next;

  // Unflatten the channel data bus.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign chan_data[gi] = in_data[gi*W +: W];
  end

  rr_arbiter #(.N(N)) u_arb (
    .req   (in_valid),
    .ptr   (ptr_reg),
    .mode  (mode),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Output stage can take a word when empty or being drained this cycle.
  always_comb begin
    load_en  = !valid_reg | out_ready;
    in_ready = load_en ? grant : '0;
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    if (load_en) begin
      if (grant_any) begin
        valid_next = 1'b1;
        data_next  = chan_data[grant_idx];
        sel_next   = grant_idx;
        if (mode == MODE_RR) begin
          ptr_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end else begin
        valid_next = 1'b0;
      end
    end
  end

  // State registers; reset discards any held word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb with N=4, W=8.
module tb_rr_mux_arb;

  localparam int W = 8;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_ready;

  int passed = 0;
  int total  = 0;

  rr_mux_arb #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; in_valid = '0; out_ready = 1'b0;
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL reset_data got=%h want=00", out_data); else passed++;
    total++; if (in_ready !== 4'b0000) $display("FAIL reset_ready got=%b want=0000", in_ready); else passed++;
    @(negedge clk); rst = 1'b0;
    // load a word from channel 1, then reset mid-clock while held
    in_valid = 4'b0010;
    tick();
    total++; if (out_valid !== 1'b1 || out_sel !== 2'd1) $display("FAIL preload got=%b/%0d want=1/1", out_valid, out_sel); else passed++;
    in_valid = '0;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL async_valid got=%b want=0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL async_data got=%h want=00", out_data); else passed++;
    total++; if (out_sel !== 2'd0) $display("FAIL async_sel got=%0d want=0", out_sel); else passed++;
    total++; if (in_ready !== 4'b0000) $display("FAIL async_ready got=%b want=0000", in_ready); else passed++;
    #1 rst = 1'b0;
  endtask

  task automatic test_rr_fairness();
    logic [7:0] exp_data [5];
    logic [1:0] exp_sel  [5];
    exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    exp_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    @(negedge clk);
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("rr xfer %0d: sel=%0d data=%h", i, out_sel, out_data);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_data[i] || out_sel !== exp_sel[i])
        $display("FAIL rr_%0d got=%b/%h/%0d want=1/%h/%0d", i, out_valid, out_data, out_sel, exp_data[i], exp_sel[i]);
      else passed++;
    end
    // ptr now 1
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0001;            // scan from 1 finds only channel 0
    tick();
    total++; if (out_data !== 8'hA0 || out_sel !== 2'd0) $display("FAIL bp_load got=%h/%0d want=a0/0", out_data, out_sel); else passed++;
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 4'b0000) $display("FAIL bp_ready_%0d got=%b want=0000", i, in_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_sel !== 2'd0)
        $display("FAIL bp_hold_%0d got=%b/%h/%0d want=1/a0/0", i, out_valid, out_data, out_sel);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0010) $display("FAIL bp_release_ready got=%b want=0010", in_ready); else passed++;
    tick();
    total++; if (out_data !== 8'hA1 || out_sel !== 2'd1) $display("FAIL bp_next got=%h/%0d want=a1/1", out_data, out_sel); else passed++;
    in_valid = '0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_consumed got=%b want=0", out_valid); else passed++;
    // ptr now 2
  endtask

  task automatic test_fixed();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (in_ready !== 4'b0010) $display("FAIL fixed_ready_%0d got=%b want=0010", i, in_ready); else passed++;
      tick();
      total++; if (out_sel !== 2'd1 || out_data !== 8'hA1) $display("FAIL fixed_sel_%0d got=%0d/%h want=1/a1", i, out_sel, out_data); else passed++;
    end
  endtask

  task automatic test_wraparound();
    // fixed mode must have left ptr at 2
    mode = 1'b0; in_valid = 4'b1111;
    #1;
    total++; if (in_ready !== 4'b0100) $display("FAIL wrap_ptr2 got=%b want=0100", in_ready); else passed++;
    tick();
    total++; if (out_sel !== 2'd2) $display("FAIL wrap_ch2 got=%0d want=2", out_sel); else passed++;
    in_valid = 4'b0001;
    #1;
    total++; if (in_ready !== 4'b0001) $display("FAIL wrap_ready0 got=%b want=0001", in_ready); else passed++;
    tick();
    total++; if (out_sel !== 2'd0 || out_data !== 8'hA0) $display("FAIL wrap_ch0 got=%0d/%h want=0/a0", out_sel, out_data); else passed++;
    in_valid = 4'b1001;
    #1;
    total++; if (in_ready !== 4'b1000) $display("FAIL wrap_ready3 got=%b want=1000", in_ready); else passed++;
    tick();
    total++; if (out_sel !== 2'd3 || out_data !== 8'hA3) $display("FAIL wrap_ch3 got=%0d/%h want=3/a3", out_sel, out_data); else passed++;
  endtask

  task automatic test_drain();
    in_data = {8'hA3, 8'h5A, 8'hA1, 8'hA0};
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sel !== 2'd2)
      $display("FAIL drain_load got=%b/%h/%0d want=1/5a/2", out_valid, out_data, out_sel);
    else passed++;
    in_valid = '0;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h5A) $display("FAIL drain_empty got=%b/%h want=0/5a", out_valid, out_data); else passed++;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h5A || out_sel !== 2'd2)
      $display("FAIL drain_hold got=%b/%h/%0d want=0/5a/2", out_valid, out_data, out_sel);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_backpressure();
    test_fixed();
    test_wraparound();
    test_drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
